// File: rtl/uart_transmitter_top.sv
// UART transmitter: 5-8 data bits LSB first, optional parity, 1/1.5/2 stops; thr_pop is combinational in the load cycle and the line falls one pclk later.
// Loads only from IDLE or at stop end (back-to-back); `UART_TX_BREAK_EN adds the brk port that forces the line low.
module uart_transmitter_top #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       utxrst,
    input  logic       baud_tick,
    input  logic [7:0] thr_data,
    input  logic       thr_valid,
    output logic       thr_pop,
    input  logic [1:0] wls,
    input  logic       stb,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    input  logic       loop,
`ifdef UART_TX_BREAK_EN
    input  logic       brk,
`endif
    output logic       uartn_txd,
    output logic       loop_txd,
    output logic       tx_busy,
    output logic       temt
);

    localparam int            CW       = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    tsr_q;
    logic [2:0]    bit_cnt_q;
    logic          par_q;
    logic          stop2_q;
    logic [1:0]    wls_q;
    logic          stb_q;
    logic          pen_q;
    logic          eps_q;
    logic          sp_q;
    logic          txd_q;
    logic          busy_q;

    logic          bit_end;
    logic          half_end;
    logic          stop_end;
    logic          load;
    logic          last_data;
    logic          par_d;
    logic          par_bit_d;
    logic [CW-1:0] cnt_d;

    assign bit_end   = baud_tick && (cnt_q == CNT_LAST) && (state_q != ST_IDLE);
    assign half_end  = baud_tick && (cnt_q == CNT_HALF);
    // stop2_q marks that the first full stop period is done; 1.5 stops then ends at the half period
    assign stop_end  = (state_q == ST_STOP) &&
                       (stb_q ? (stop2_q && ((wls_q == 2'b00) ? half_end : bit_end)) : bit_end);
    assign load      = !utxrst && thr_valid && ((state_q == ST_IDLE) || stop_end);
    assign last_data = (bit_cnt_q == (3'd4 + {1'b0, wls_q}));
    assign par_d     = par_q ^ tsr_q[0];
    assign par_bit_d = sp_q ? ~eps_q : (eps_q ? par_d : ~par_d);
    assign cnt_d     = (bit_end || stop_end) ? '0 : cnt_q + CW'(1);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tsr_q     <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            stop2_q   <= 1'b0;
            wls_q     <= '0;
            stb_q     <= 1'b0;
            pen_q     <= 1'b0;
            eps_q     <= 1'b0;
            sp_q      <= 1'b0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else if (utxrst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tsr_q     <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            stop2_q   <= 1'b0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else if (load) begin
            state_q   <= ST_START;
            cnt_q     <= '0;
            tsr_q     <= thr_data;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            stop2_q   <= 1'b0;
            wls_q     <= wls;
            stb_q     <= stb;
            pen_q     <= pen;
            eps_q     <= eps;
            sp_q      <= sp;
            txd_q     <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            if (baud_tick && (state_q != ST_IDLE)) begin
                cnt_q <= cnt_d;
            end
            case (state_q)
                ST_IDLE: begin
                    txd_q  <= 1'b1;
                    busy_q <= 1'b0;
                end
                ST_START: begin
                    if (bit_end) begin
                        state_q <= ST_DATA;
                        txd_q   <= tsr_q[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        tsr_q     <= {1'b0, tsr_q[7:1]};
                        par_q     <= par_d;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (last_data) begin
                            if (pen_q) begin
                                state_q <= ST_PARITY;
                                txd_q   <= par_bit_d;
                            end else begin
                                state_q <= ST_STOP;
                                txd_q   <= 1'b1;
                            end
                        end else begin
                            txd_q <= tsr_q[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state_q <= ST_STOP;
                        txd_q   <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (stop_end) begin
                        state_q <= ST_IDLE;
                        txd_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (bit_end) begin
                        stop2_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Gating with presetn keeps thr_pop low while the block is held in reset
    assign thr_pop = presetn && load;

`ifdef UART_TX_BREAK_EN
    assign loop_txd  = txd_q & ~brk;
    assign uartn_txd = loop | (txd_q & ~brk);
`else
    assign loop_txd  = txd_q;
    assign uartn_txd = loop | txd_q;
`endif

    assign tx_busy = busy_q;
    assign temt    = !busy_q && !thr_valid;

endmodule

// File: tb/tb_uart_transmitter_top.sv
// Directed bench for uart_transmitter_top: a vector table of single frames plus hand-written multi-frame and reset sequences.
module tb_uart_transmitter_top;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       utxrst;
    logic       baud_tick;
    logic [7:0] thr_data;
    logic       thr_valid;
    logic       thr_pop;
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       eps;
    logic       sp;
    logic       loop;
    logic       brk;
    logic       uartn_txd;
    logic       loop_txd;
    logic       tx_busy;
    logic       temt;

    int n_tests = 0;
    int n_fail  = 0;
    int tdiv    = 0;

    always #5 pclk = ~pclk;

    uart_transmitter_top #(.OVERSAMPLE(16)) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .utxrst    (utxrst),
        .baud_tick (baud_tick),
        .thr_data  (thr_data),
        .thr_valid (thr_valid),
        .thr_pop   (thr_pop),
        .wls       (wls),
        .stb       (stb),
        .pen       (pen),
        .eps       (eps),
        .sp        (sp),
        .loop      (loop),
`ifdef UART_TX_BREAK_EN
        .brk       (brk),
`endif
        .uartn_txd (uartn_txd),
        .loop_txd  (loop_txd),
        .tx_busy   (tx_busy),
        .temt      (temt)
    );

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  wls;
        logic        stb;
        logic        pen;
        logic        eps;
        logic        sp;
        logic        lp;
        int          nsym;
        logic [11:0] exp_sym;   // bit k = level of symbol k, start bit at bit 0
        int          exp_ticks;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        n_tests++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
        end
    endtask

    // pre: drive baud_tick for this cycle and wait to the sampling point; post: cross the active edge.
    task automatic pre();
        baud_tick = (tdiv == 3);
        @(negedge pclk);
    endtask

    task automatic post();
        @(posedge pclk);
        #1;
        tdiv = (tdiv + 1) % 4;
    endtask

    task automatic set_cfg(input logic [1:0] w, input logic s, input logic p,
                           input logic e, input logic k, input logic l);
        wls = w; stb = s; pen = p; eps = e; sp = k; loop = l;
    endtask

    task automatic run_frame(input vec_t v, output int pops, output int ticks, output int mids,
                             output int bad, output int pin_err, output int temt_end, output int tmo);
        logic        seen;
        logic        done;
        logic        line;
        logic        expb;
        logic [11:0] m;
        int          k;
        int          ncyc;
        pops = 0; ticks = 0; bad = 0; pin_err = 0; temt_end = 0; tmo = 0;
        m = '0; seen = 1'b0; done = 1'b0; ncyc = 0;
        thr_data = v.data;
        set_cfg(v.wls, v.stb, v.pen, v.eps, v.sp, v.lp);
        thr_valid = 1'b1;
        tdiv = 3;
        while (!done) begin
            pre();
            line = v.lp ? loop_txd : uartn_txd;
            if (thr_pop) pops++;
            if (v.lp ? (uartn_txd !== 1'b1) : (loop_txd !== uartn_txd)) pin_err++;
            if (tx_busy) begin
                seen = 1'b1;
                if (baud_tick) begin
                    k = ticks / 16;
                    expb = (k < v.nsym) ? v.exp_sym[k] : 1'b1;
                    if (line !== expb) bad++;
                    if ((ticks % 16 == 8) && (k < 12)) m[k] = line;
                    ticks++;
                end
            end else if (seen) begin
                temt_end = int'(temt);
                done = 1'b1;
            end
            post();
            if (pops > 0) thr_valid = 1'b0;
            ncyc++;
            if (ncyc > 2000) begin
                tmo = 1;
                done = 1'b1;
            end
        end
        mids = int'(m);
        loop = 1'b0;
    endtask

    task automatic run_ticks(input int n, output int tmo);
        int ticks;
        int ncyc;
        ticks = 0; ncyc = 0; tmo = 0;
        while ((ticks < n) && (tmo == 0)) begin
            pre();
            if (tx_busy && baud_tick) ticks++;
            if (thr_pop) begin
                post();
                thr_valid = 1'b0;
            end else begin
                post();
            end
            ncyc++;
            if (ncyc > 2000) tmo = 1;
        end
    endtask

    initial begin : main
        int pops, ticks, mids, bad, pin_err, temt_end, tmo;
        logic [7:0] bytes [3];
        logic [7:0] b;
        int  idx, k, f, gap, pop_idle, temt_rise, ncyc;
        logic seen, done, prev_temt, expb, popped;

        vecs[0] = '{8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 12'h34A, 160};
        vecs[1] = '{8'hFF, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10, 12'h3FE, 160};
        vecs[2] = '{8'hE0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,  8, 12'h0C0, 136};
        vecs[3] = '{8'h2A, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  9, 12'h1D4, 144};
        vecs[4] = '{8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10, 12'h278, 160};
        vecs[5] = '{8'h07, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11, 12'h40E, 176};
        vecs[6] = '{8'h3F, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,  8, 12'h0FE, 128};
        vecs[7] = '{8'hFF, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 11, 12'h5FE, 176};

        presetn = 1'b0; utxrst = 1'b0; baud_tick = 1'b0; thr_data = 8'h00; thr_valid = 1'b0;
        brk = 1'b0;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(negedge pclk);
        chk("rst uartn_txd", uartn_txd, 1);
        chk("rst loop_txd", loop_txd, 1);
        chk("rst tx_busy", tx_busy, 0);
        chk("rst thr_pop", thr_pop, 0);
        chk("rst temt", temt, 1);
        thr_valid = 1'b1;
        #1;
        chk("rst thr_pop valid", thr_pop, 0);
        chk("rst temt valid", temt, 0);
        thr_valid = 1'b0;
        @(posedge pclk);
        #1;
        presetn = 1'b1;

        // Single-frame vector table
        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i], pops, ticks, mids, bad, pin_err, temt_end, tmo);
            chk($sformatf("v%0d timeout", i), tmo, 0);
            chk($sformatf("v%0d pops", i), pops, 1);
            chk($sformatf("v%0d ticks", i), ticks, vecs[i].exp_ticks);
            chk($sformatf("v%0d mid bits", i), mids, int'(vecs[i].exp_sym));
            chk($sformatf("v%0d bad ticks", i), bad, 0);
            chk($sformatf("v%0d pin routing", i), pin_err, 0);
            chk($sformatf("v%0d temt end", i), temt_end, 1);
        end

        // Back-to-back frames 01, 02, 03 in 8N1
        bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
        idx = 0; pops = 0; ticks = 0; bad = 0; gap = 0; pop_idle = 0; temt_rise = 0; ncyc = 0;
        seen = 1'b0; done = 1'b0; tmo = 0;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        thr_data = bytes[0];
        thr_valid = 1'b1;
        tdiv = 3;
        prev_temt = 1'b0;
        while (!done) begin
            pre();
            popped = thr_pop;
            if (thr_pop) begin
                pops++;
                if ((pops > 1) && !tx_busy) pop_idle++;
            end
            if (temt && !prev_temt) temt_rise++;
            prev_temt = temt;
            if (tx_busy) begin
                seen = 1'b1;
                if (baud_tick) begin
                    f = ticks / 160;
                    k = (ticks % 160) / 16;
                    b = (f < 3) ? bytes[f] : 8'h00;
                    expb = (k == 0) ? 1'b0 : ((k == 9) ? 1'b1 : b[k-1]);
                    if (uartn_txd !== expb) bad++;
                    ticks++;
                end
            end else if (seen) begin
                if (thr_valid) gap++;
                else done = 1'b1;
            end
            post();
            if (popped) begin
                idx++;
                if (idx < 3) thr_data = bytes[idx];
                else thr_valid = 1'b0;
            end
            ncyc++;
            if (ncyc > 3000) begin
                tmo = 1;
                done = 1'b1;
            end
        end
        chk("b2b timeout", tmo, 0);
        chk("b2b pops", pops, 3);
        chk("b2b ticks", ticks, 480);
        chk("b2b bad ticks", bad, 0);
        chk("b2b idle gap", gap, 0);
        chk("b2b pop while idle", pop_idle, 0);
        chk("b2b temt rises", temt_rise, 1);

        // Soft reset during DATA bit 3 of 8'h00
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        thr_data = 8'h00;
        thr_valid = 1'b1;
        tdiv = 3;
        run_ticks(69, tmo);
        chk("utxrst reach timeout", tmo, 0);
        pre();
        chk("utxrst line before", uartn_txd, 0);
        post();
        utxrst = 1'b1;
        thr_valid = 1'b1;
        pre();
        chk("utxrst pop held", thr_pop, 0);
        post();
        utxrst = 1'b0;
        thr_valid = 1'b0;
        pre();
        chk("utxrst line", uartn_txd, 1);
        chk("utxrst busy", tx_busy, 0);
        chk("utxrst temt", temt, 1);
        post();

        // Async reset mid-frame
        thr_data = 8'h00;
        thr_valid = 1'b1;
        tdiv = 3;
        run_ticks(30, tmo);
        chk("arst reach timeout", tmo, 0);
        #2;
        presetn = 1'b0;
        #1;
        chk("arst line", uartn_txd, 1);
        chk("arst busy", tx_busy, 0);
        thr_valid = 1'b1;
        #1;
        chk("arst pop", thr_pop, 0);
        thr_valid = 1'b0;
        @(posedge pclk);
        #1;
        presetn = 1'b1;

`ifdef UART_TX_BREAK_EN
        // Break forces both outputs low while the frame timing carries on
        thr_data = 8'h00;
        thr_data = 8'hFF;
        thr_valid = 1'b1;
        tdiv = 3;
        pops = 0; ticks = 0; bad = 0; pin_err = 0; ncyc = 0; seen = 1'b0; done = 1'b0; tmo = 0;
        while (!done) begin
            brk = (ticks >= 40) && (ticks < 60);
            pre();
            if (thr_pop) pops++;
            if (brk && ((uartn_txd !== 1'b0) || (loop_txd !== 1'b0))) pin_err++;
            if (tx_busy) begin
                seen = 1'b1;
                if (baud_tick) begin
                    expb = (ticks < 16) ? 1'b0 : 1'b1;
                    if (!brk && (uartn_txd !== expb)) bad++;
                    ticks++;
                end
            end else if (seen) begin
                done = 1'b1;
            end
            post();
            if (pops > 0) thr_valid = 1'b0;
            ncyc++;
            if (ncyc > 2000) begin
                tmo = 1;
                done = 1'b1;
            end
        end
        brk = 1'b0;
        chk("brk timeout", tmo, 0);
        chk("brk forced low", pin_err, 0);
        chk("brk ticks", ticks, 160);
        chk("brk resume bits", bad, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_transmitter_top.md
# uart_transmitter_top

Serial transmit half of the UART. It takes a byte from the transmit holding register and serializes it onto `uartn_txd`: start bit, 5–8 data bits LSB first, optional parity, then 1, 1.5 or 2 stop bits. It is the counterpart of the receiver path and shares its `baud_tick` oversample strobe and line-control fields (`wls`, `pen`, `eps`, `sp`). In loopback it drives `loop_txd` into the receiver and holds the pin idle.

## Interface
Parameters:
- `OVERSAMPLE`, 16: `baud_tick` pulses per bit period.

Ports:
- `pclk` in 1: the single clock for the block.
- `presetn` in 1: reset, asynchronous and active-low.
- `utxrst` in 1: synchronous soft reset, active-high. Returns the block to IDLE.
- `baud_tick` in 1: one-`pclk` strobe at `OVERSAMPLE` × baud rate.
- `thr_data` in 8: byte to send.
- `thr_valid` in 1: the holding register is non-empty.
- `thr_pop` out 1: one-cycle pulse. `thr_data` was accepted this cycle.
- `wls` in 2: word length. 00→5, 01→6, 10→7, 11→8 bits.
- `stb` in 1: stop bits. 0→1; 1→2, or 1.5 when `wls`=00.
- `pen`, `eps`, `sp` in 1 each: parity enable, even parity select, stick parity.
- `loop` in 1: loopback enable.
- `brk` in 1: break control. Present only with `UART_TX_BREAK_EN`.
- `uartn_txd` out 1: serial output pin.
- `loop_txd` out 1: serial stream to the receiver.
- `tx_busy` out 1: high from load until the end of the last stop bit.
- `temt` out 1: transmitter empty. High when `!tx_busy && !thr_valid`.

## Operation
- States are IDLE, START, DATA, PARITY and STOP.
- Load happens in IDLE when `thr_valid`=1. In that same cycle:
  - `thr_pop`=1;
  - `thr_data` is copied into the 8-bit TSR;
  - `wls`, `stb`, `pen`, `eps` and `sp` are latched for the frame;
  - the tick counter is cleared;
  - next state is START.
- Config changes mid-frame have no effect until the next load.
- Bit period:
  - A 4-bit tick counter increments on each `baud_tick`.
  - A bit ends on the tick that brings the count to `OVERSAMPLE`; the counter then wraps to 0.
  - A 1.5-stop-bit frame ends its STOP state after 24 ticks.
- Serial level per state:
  - IDLE: 1.
  - START: 0.
  - DATA: TSR[0]. The TSR shifts right at each bit end.
  - PARITY: parity bit.
  - STOP: 1.
- State transitions:
  - START → DATA.
  - DATA → PARITY after 5+`wls` bits if `pen`=1, otherwise DATA → STOP.
  - PARITY → STOP.
  - STOP → IDLE.
- Back-to-back frames: at the end of STOP with `thr_valid`=1, the block loads directly and goes STOP → START. There is no idle gap.
- Parity bit, with P = XOR of the transmitted data bits only (unused high bits excluded):
  - `sp`=0, `eps`=1: parity bit = P (even parity).
  - `sp`=0, `eps`=0: parity bit = ~P (odd parity).
  - `sp`=1: parity bit = ~`eps`.
- Output routing:
  - `loop_txd` = serial level.
  - `uartn_txd` = `loop` ? 1 : serial level. `loop` acts combinationally on the output mux.
- Soft reset: `utxrst`=1 overrides everything. In that cycle:
  - the state goes to IDLE;
  - the counter and TSR clear;
  - `thr_pop` is held at 0.

## Timing
- Reset values (from `presetn` low, and the cycle after `utxrst`):
  - `uartn_txd`=1, `loop_txd`=1, `tx_busy`=0, `thr_pop`=0;
  - `temt` = `!thr_valid`;
  - state IDLE, counter 0, TSR 0.
- Load latency: `uartn_txd` falls one `pclk` after the load cycle. `tx_busy` rises on that same edge.
- Frame length, in `baud_tick`s: `OVERSAMPLE` × (1 + data bits + `pen` + stop bits).
  - Example: 8N1 = 160.
- `tx_busy` falls in the cycle after the final stop-bit tick, unless the block reloads back-to-back.
- At most one `thr_pop` is issued per frame. `thr_pop` never asserts while `tx_busy`=1, except at the back-to-back STOP-end edge.
- `baud_tick` and load in the same cycle: the tick is ignored, because the counter is cleared.
- `presetn` or `utxrst` asserted mid-frame: the frame is aborted, the line returns to 1 immediately, and no `thr_pop` is issued.

## Configuration
- Macro: `UART_TX_BREAK_EN`.
- Defined:
  - The `brk` port exists.
  - While `brk`=1, `uartn_txd`=0 and `loop_txd`=0, regardless of state. Loopback mode still keeps `uartn_txd` at 1.
  - The FSM keeps running underneath, so frame timing is unaffected.
- Undefined:
  - There is no `brk` port.
  - Outputs follow Operation only.

## Test plan
- 8N1, `thr_data`=8'hA5, `baud_tick` every 4 `pclk` → one `thr_pop`; line sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 16 ticks; `tx_busy` high for 160 ticks.
- 7E1, `thr_data`=8'hFF (`wls`=10, `pen`=1, `eps`=1) → 7 data ones, parity 1, stop; bit 7 never transmitted.
- 5-bit, `stb`=1, `sp`=1, `eps`=0 → parity bit 1; stop held 24 ticks; 6-bit with `stb`=1 → stop held 32 ticks.
- `thr_valid` held high for 3 bytes 8'h01, 8'h02, 8'h03 → 3 `thr_pop`s, each at STOP end; line never idles between frames; `temt` rises once, after the 3rd stop.
- `loop`=1 sending 8'h3C → `uartn_txd` constant 1; `loop_txd` carries the full frame.
- `utxrst` pulse during DATA bit 3 → next cycle line=1, `tx_busy`=0, no `thr_pop`. With `UART_TX_BREAK_EN` defined, `brk`=1 during a frame → `uartn_txd`=0 until `brk` drops, after which the frame resumes at its current bit.
